// File: rtl/lsu.sv
// Multi-cycle load/store unit between execute and writeback.
// One op in flight; drives a word-addressed req/gnt/rvalid data-memory port.
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

    logic              legal, aligned;
    logic [DATA_W-1:0] shifted, ext;

    // Width code: [1:0]=00 byte, 01 half, 10 word; bit 2 selects zero-extend on loads.
    always_comb begin
        if (req_wen)
            legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
        else
            legal = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
        case (req_funct3[1:0])
            2'b01:   aligned = !req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  ext = mem_rdata;
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                funct3_d = req_funct3;
                off_d    = req_addr[1:0];
                wen_d    = req_wen;
                addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
                // Stores are lane-replicated so the strobe alone picks the bytes.
                case (req_funct3[1:0])
                    2'b00: begin
                        wdata_d = {4{req_wdata[7:0]}};
                        strb_d  = 4'b0001 << req_addr[1:0];
                    end
                    2'b01: begin
                        wdata_d = {2{req_wdata[15:0]}};
                        strb_d  = req_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        wdata_d = req_wdata;
                        strb_d  = 4'b1111;
                    end
                endcase
                if (!req_wen) begin
                    wdata_d = '0;
                    strb_d  = 4'b0000;
                end
                if (legal && aligned) begin
                    state_d = REQ;
                end else begin
                    state_d    = DONE;
                    resp_err_d = 1'b1;
                end
            end
            REQ:  if (mem_gnt) state_d = WAIT;
            WAIT: if (mem_rvalid) begin
                state_d      = DONE;
                resp_err_d   = mem_err;
                resp_rdata_d = (mem_err || wen_q) ? '0 : ext;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        mem_req_d    = (state_d == REQ);
        mem_we_d     = mem_req_d && wen_d;
        mem_addr_d   = mem_req_d ? addr_d  : '0;
        mem_wdata_d  = mem_req_d ? wdata_d : '0;
        mem_wstrb_d  = mem_req_d ? strb_d  : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            off_q        <= '0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected responses queue up at issue and are popped on resp_valid.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    // Scoreboard: every resp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            chk("sb_pending", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_rdata", resp_rdata, e.data);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int gdly, input logic [31:0] rword,
                          input logic merr, input logic mem_exp, input logic [31:0] eaddr,
                          input logic [3:0] estrb, input logic [31:0] ewdata,
                          input logic [31:0] erdata, input logic eerr);
        exp_t e;
        wait_ready();
        e.err  = eerr;
        e.data = erdata;
        sbq.push_back(e);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (mem_exp) begin
            for (int i = 0; i <= gdly; i++) begin
                @(negedge clk);
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_we", 32'(mem_we), 32'(wen));
                chk("mem_addr", mem_addr, eaddr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(estrb));
                chk("mem_wdata", mem_wdata, ewdata);
                chk("early_resp", 32'(resp_valid), 32'd0);
                mem_gnt = (i == gdly);
                @(posedge clk);
                #1 mem_gnt = 1'b0;
            end
            @(negedge clk);
            chk("req_drop", 32'(mem_req), 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = rword;
            mem_err    = merr;
            @(posedge clk);
            #1 mem_rvalid = 1'b0;
            mem_err = 1'b0;
            @(negedge clk);
            chk("resp_lat", 32'(resp_valid), 32'd1);
        end else begin
            @(negedge clk);
            chk("no_mem_req", 32'(mem_req), 32'd0);
            chk("resp_lat", 32'(resp_valid), 32'd1);
        end
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // wen addr wdata f3 gdly rword merr mem eaddr strb ewdata erdata eerr
        run_op(0, 32'h80000010, 0, 3'b010, 0, 32'hDEADBEEF, 0, 1, 32'h80000010, 4'b0000, 0, 32'hDEADBEEF, 0);
        run_op(0, 32'h80000003, 0, 3'b000, 0, 32'h80FF7F01, 0, 1, 32'h80000000, 4'b0000, 0, 32'hFFFFFF80, 0);
        run_op(0, 32'h80000003, 0, 3'b100, 1, 32'h80FF7F01, 0, 1, 32'h80000000, 4'b0000, 0, 32'h00000080, 0);
        run_op(0, 32'h80000002, 0, 3'b001, 0, 32'h80FF7F01, 0, 1, 32'h80000000, 4'b0000, 0, 32'hFFFF80FF, 0);
        run_op(0, 32'h80000000, 0, 3'b101, 0, 32'h80FF8F01, 0, 1, 32'h80000000, 4'b0000, 0, 32'h00008F01, 0);
        run_op(0, 32'h80000001, 0, 3'b000, 0, 32'h80FF7F01, 0, 1, 32'h80000000, 4'b0000, 0, 32'h0000007F, 0);
        run_op(1, 32'h80000001, 32'h123456AB, 3'b000, 3, 0, 0, 1, 32'h80000000, 4'b0010, 32'hABABABAB, 0, 0);
        run_op(1, 32'h80000006, 32'h1234CAFE, 3'b001, 0, 0, 0, 1, 32'h80000004, 4'b1100, 32'hCAFECAFE, 0, 0);
        run_op(1, 32'h80000008, 32'h01020304, 3'b010, 2, 0, 0, 1, 32'h80000008, 4'b1111, 32'h01020304, 0, 0);
        run_op(0, 32'h80000002, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_op(0, 32'h80000000, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_op(0, 32'h80000001, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_op(1, 32'h80000000, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_op(0, 32'h80000004, 0, 3'b010, 0, 32'h55AA55AA, 1, 1, 32'h80000004, 4'b0000, 0, 0, 1);

        // Reset while WAIT: the late response must be dropped.
        wait_ready();
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000020; req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        run_op(0, 32'h80000024, 0, 3'b010, 0, 32'hCAFEF00D, 0, 1, 32'h80000024, 4'b0000, 0, 32'hCAFEF00D, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
